qcodec_frame_sched: RTL and testbench
=====================================

# qcodec_frame_sched

Frame scheduler for the codec datapath. It sequences one image frame at a time through the pixel core by generating a raster-order stream of pixel coordinates under a valid/ready handshake. It marks the first and last pixel and requests an end-of-stream flush from the core. It reports completion, configuration errors and aborts to the host-side control logic.

## Interface
Parameters:
- DIM_W, 16, width of frame width/height and of the x/y coordinates
- IDX_W, 2*DIM_W, width of the linear pixel index

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the current frame
- cfg_width  in  DIM_W  frame width in pixels, latched on accepted start
- cfg_height  in  DIM_W  frame height in pixels, latched on accepted start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a frame completes normally
- err_cfg  out  1  one-cycle pulse when start is given with a zero dimension
- px_valid  out  1  coordinate beat valid
- px_ready  in  1  core accepts the beat
- px_x  out  DIM_W  column of the current beat
- px_y  out  DIM_W  row of the current beat
- px_idx  out  IDX_W  linear index, y*width+x
- px_first  out  1  current beat is pixel (0,0)
- px_last  out  1  current beat is pixel (W-1,H-1)
- flush_req  out  1  request that the core emit its end-of-stream data
- flush_ack  in  1  core has finished flushing

## Operation
- States: IDLE, ISSUE, FLUSH.
- IDLE:
  - start=1 with both cfg dims nonzero: latch the dims, clear x/y/idx, go to ISSUE.
  - start=1 with either dim zero: stay in IDLE and pulse err_cfg. No beats are issued.
- ISSUE:
  - px_valid=1.
  - A handshake (px_valid & px_ready) advances the position:
    - x<W-1: x+1.
    - x=W-1: x=0, y+1.
    - idx increments by 1 on every handshake.
  - A handshake on the last pixel goes to FLUSH.
- FLUSH:
  - px_valid=0 and flush_req=1, held until flush_ack=1 is sampled.
  - Then go to IDLE and pulse done.
- Combinational decode from the registered state:
  - px_first = (x==0 && y==0).
  - px_last = (x==W-1 && y==H-1).
- Handshake rules:
  - While px_valid=1 and px_ready=0, px_x, px_y, px_idx, px_first and px_last are held stable.
  - px_valid never drops without a handshake, except on abort or rst.
- Abort: abort=1 in any state forces IDLE next cycle.
  - px_valid=0 and flush_req=0; no done pulse.
  - abort has priority over a simultaneous handshake, start or flush_ack.
  - abort in IDLE has no effect.
- start is ignored while busy=1.
- flush_ack is ignored outside FLUSH.
- Arithmetic: idx is IDX_W wide. It must not wrap for the maximum frame of (2^DIM_W-1)^2 pixels. No multiplier is used; idx is a counter.

## Timing
- Reset values: busy=0, done=0, err_cfg=0, px_valid=0, px_x=0, px_y=0, px_idx=0, px_first=0, px_last=0, flush_req=0. State is IDLE.
- rst mid-frame behaves like abort: outputs reach their reset values the cycle after rst is sampled.
- Accepted start at cycle N: busy=1 and px_valid=1 with (0,0) at N+1.
- With px_ready held high, one beat per cycle. A W×H frame occupies cycles N+1 .. N+W*H.
- Last handshake at cycle M: px_valid=0 and flush_req=1 at M+1.
- flush_ack sampled at cycle K: flush_req=0, busy=0 and done=1 at K+1; done=0 at K+2.
- flush_ack may already be high at M+1; done is then at M+2.
- err_cfg pulses at N+1; busy stays 0.
- A start sampled in the same cycle that done=1 is accepted. Back-to-back frames are separated only by that one IDLE cycle.
- 1×1 frame: a single beat carries px_first=px_last=1 and idx=0.

## Test plan
- 4×2 frame, px_ready=1, flush_ack asserted 3 cycles after flush_req:
  - 8 consecutive beats (0,0)..(3,0),(0,1)..(3,1) with idx 0..7.
  - px_first only on beat 0; px_last only on beat 7.
  - flush_req for 3 cycles, then a single done pulse with busy=0.
- 3×3 frame with px_ready toggling pseudo-randomly: coordinates are stable during stalls, exactly 9 handshakes occur, and idx at the final handshake is 8.
- 1×1 frame: one beat at (0,0) with first=last=1, then flush and done. Separately, width=0 height=5: err_cfg pulses once, px_valid is never asserted, busy stays 0.
- 5×4 frame, abort asserted at the handshake of idx 7:
  - px_valid=0 next cycle; no done; no flush_req.
  - A following 2×2 frame starts cleanly at (0,0) with idx 0.
- start pulsed during ISSUE with cfg 9×9 on a running 2×3 frame: the pulse is ignored and only 6 beats are issued. start in the done cycle launches the next frame one cycle later.
- rst asserted during FLUSH, with flush_ack high in the same cycle: all outputs return to their reset values next cycle and no done pulse is produced.

Source files
------------

// File: rtl/qcodec_frame_sched.sv
// Frame scheduler: walks one frame in raster order under valid/ready,
// then requests an end-of-stream flush from the pixel core.
//
// state | meaning
// IDLE  | waiting for start; dims and position are don't-care
// ISSUE | presenting pixel beats (px_valid=1)
// FLUSH | frame fully issued; flush_req held until flush_ack
module qcodec_frame_sched #(
  parameter int DIM_W = 16,
  parameter int IDX_W = 2 * DIM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [DIM_W-1:0] px_x,
  output logic [DIM_W-1:0] px_y,
  output logic [IDX_W-1:0] px_idx,
  output logic             px_first,
  output logic             px_last,
  output logic             flush_req,
  input  logic             flush_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIM_W-1:0] w_q, w_d;
  logic [DIM_W-1:0] h_q, h_d;
  logic             done_q, done_d;
  logic             err_cfg_q, err_cfg_d;

  logic             in_issue;
  logic             hs;
  logic             at_last_x;
  logic             at_last_y;

  assign in_issue  = (state_q == ISSUE);
  assign hs        = in_issue && px_ready;
  assign at_last_x = (x_q == (w_q - DIM_W'(1)));
  assign at_last_y = (y_q == (h_q - DIM_W'(1)));

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    w_d       = w_q;
    h_d       = h_q;
    done_d    = 1'b0;
    err_cfg_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if ((cfg_width != '0) && (cfg_height != '0)) begin
              state_d = ISSUE;
              w_d     = cfg_width;
              h_d     = cfg_height;
              x_d     = '0;
              y_d     = '0;
              idx_d   = '0;
            end else begin
              err_cfg_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            if (at_last_x && at_last_y) begin
              // position cleared so IDLE/FLUSH present zeros on the bus
              state_d = FLUSH;
              x_d     = '0;
              y_d     = '0;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              if (at_last_x) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
              end else begin
                x_d = x_q + DIM_W'(1);
              end
            end
          end
        end
        FLUSH: begin
          if (flush_ack) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      w_q       <= '0;
      h_q       <= '0;
      done_q    <= 1'b0;
      err_cfg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      w_q       <= w_d;
      h_q       <= h_d;
      done_q    <= done_d;
      err_cfg_q <= err_cfg_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err_cfg   = err_cfg_q;
  assign px_valid  = in_issue;
  assign flush_req = (state_q == FLUSH);
  assign px_x      = x_q;
  assign px_y      = y_q;
  assign px_idx    = idx_q;
  // first/last only meaningful on a live beat; zero otherwise
  assign px_first  = in_issue && (x_q == '0) && (y_q == '0);
  assign px_last   = in_issue && at_last_x && at_last_y;

endmodule

// File: tb/tb_qcodec_frame_sched.sv
// Directed bench for qcodec_frame_sched: hand-computed raster expectations,
// stalls, abort, rejected configs, back-to-back frames and reset in FLUSH.
module tb_qcodec_frame_sched;

  localparam int DIM_W = 16;
  localparam int IDX_W = 2 * DIM_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;
  logic             busy;
  logic             done;
  logic             err_cfg;
  logic             px_valid;
  logic             px_ready;
  logic [DIM_W-1:0] px_x;
  logic [DIM_W-1:0] px_y;
  logic [IDX_W-1:0] px_idx;
  logic             px_first;
  logic             px_last;
  logic             flush_req;
  logic             flush_ack;

  int n_tests = 0;
  int n_fail  = 0;

  qcodec_frame_sched #(.DIM_W(DIM_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_idx     (px_idx),
    .px_first   (px_first),
    .px_last    (px_last),
    .flush_req  (flush_req),
    .flush_ack  (flush_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int w, input int h);
    start      = 1'b1;
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    tick();
    start      = 1'b0;
  endtask

  // Walks a frame with px_ready=1; optional start injection and abort at a beat.
  task automatic run_beats(input int w, input int h, input int inj_at,
                           input int abort_at, input string tg);
    for (int b = 0; b < w * h; b++) begin
      chk({tg, "_valid"}, 64'(px_valid), 64'd1);
      chk({tg, "_x"},     64'(px_x),     64'(b % w));
      chk({tg, "_y"},     64'(px_y),     64'(b / w));
      chk({tg, "_idx"},   64'(px_idx),   64'(b));
      chk({tg, "_first"}, 64'(px_first), 64'(b == 0));
      chk({tg, "_last"},  64'(px_last),  64'(b == w * h - 1));
      px_ready = 1'b1;
      if (b == inj_at) begin
        start      = 1'b1;
        cfg_width  = 16'd9;
        cfg_height = 16'd9;
      end
      if (b == abort_at) abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (b == abort_at) return;
    end
  endtask

  // flush_req observed for n cycles, ack raised in the last; ends in the done cycle.
  task automatic finish_flush(input int n, input string tg);
    for (int f = 0; f < n; f++) begin
      chk({tg, "_freq"},   64'(flush_req), 64'd1);
      chk({tg, "_fvalid"}, 64'(px_valid),  64'd0);
      chk({tg, "_fdone"},  64'(done),      64'd0);
      if (f == n - 1) flush_ack = 1'b1;
      tick();
    end
    flush_ack = 1'b0;
    chk({tg, "_done"},     64'(done),      64'd1);
    chk({tg, "_donebusy"}, 64'(busy),      64'd0);
    chk({tg, "_donefreq"}, 64'(flush_req), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tg);
    chk({tg, "_busy"},  64'(busy),      64'd0);
    chk({tg, "_done"},  64'(done),      64'd0);
    chk({tg, "_err"},   64'(err_cfg),   64'd0);
    chk({tg, "_valid"}, 64'(px_valid),  64'd0);
    chk({tg, "_x"},     64'(px_x),      64'd0);
    chk({tg, "_y"},     64'(px_y),      64'd0);
    chk({tg, "_idx"},   64'(px_idx),    64'd0);
    chk({tg, "_first"}, 64'(px_first),  64'd0);
    chk({tg, "_last"},  64'(px_last),   64'd0);
    chk({tg, "_freq"},  64'(flush_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pat;
    int          ex, ey, eidx, hs, last_idx, cyc;

    rst = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b0; flush_ack = 1'b0;
    cfg_width = '0; cfg_height = '0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("rst");

    // 4x2 frame, ack three cycles into flush
    px_ready = 1'b1;
    launch(4, 2);
    chk("f42_busy", 64'(busy), 64'd1);
    run_beats(4, 2, -1, -1, "f42");
    finish_flush(3, "f42");
    tick();
    chk("f42_done_clr", 64'(done), 64'd0);

    // 3x3 frame with stalls; model holds position while ready is low
    pat = 32'hB5A3_6C1D;
    ex = 0; ey = 0; eidx = 0; hs = 0; last_idx = -1; cyc = 0;
    px_ready = 1'b0;
    launch(3, 3);
    while (!flush_req && cyc < 100) begin
      if (px_valid) begin
        chk("f33_x",   64'(px_x),   64'(ex));
        chk("f33_y",   64'(px_y),   64'(ey));
        chk("f33_idx", 64'(px_idx), 64'(eidx));
        chk("f33_last", 64'(px_last), 64'(ex == 2 && ey == 2));
        px_ready = pat[cyc % 32];
        if (px_ready) begin
          hs++;
          last_idx = int'(px_idx);
          eidx++;
          if (ex == 2) begin ex = 0; ey++; end
          else ex++;
        end
      end
      tick();
      cyc++;
    end
    px_ready = 1'b0;
    chk("f33_timeout", 64'(flush_req), 64'd1);
    chk("f33_hs", 64'(hs), 64'd9);
    chk("f33_lastidx", 64'(last_idx), 64'd8);
    finish_flush(1, "f33");
    tick();

    // 1x1 frame
    px_ready = 1'b1;
    launch(1, 1);
    run_beats(1, 1, -1, -1, "f11");
    finish_flush(1, "f11");
    tick();

    // zero width rejected
    launch(0, 5);
    chk("zcfg_err",   64'(err_cfg),  64'd1);
    chk("zcfg_busy",  64'(busy),     64'd0);
    chk("zcfg_valid", 64'(px_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zcfg_err_clr", 64'(err_cfg),  64'd0);
      chk("zcfg_busy2",   64'(busy),     64'd0);
      chk("zcfg_valid2",  64'(px_valid), 64'd0);
    end

    // 5x4 aborted at the handshake of idx 7
    launch(5, 4);
    run_beats(5, 4, -1, 7, "f54");
    chk("ab_valid", 64'(px_valid),  64'd0);
    chk("ab_freq",  64'(flush_req), 64'd0);
    chk("ab_busy",  64'(busy),      64'd0);
    chk("ab_done",  64'(done),      64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_done2", 64'(done),      64'd0);
      chk("ab_freq2", 64'(flush_req), 64'd0);
    end
    launch(2, 2);
    run_beats(2, 2, -1, -1, "f22");
    finish_flush(1, "f22");
    tick();

    // start during ISSUE ignored; start in done cycle launches next frame
    launch(2, 3);
    run_beats(2, 3, 2, -1, "f23");
    finish_flush(1, "f23");
    launch(2, 2);
    chk("b2b_busy",  64'(busy),     64'd1);
    chk("b2b_valid", 64'(px_valid), 64'd1);
    run_beats(2, 2, -1, -1, "b2b");
    chk("b2b_freq", 64'(flush_req), 64'd1);

    // rst in FLUSH together with flush_ack
    rst = 1'b1;
    flush_ack = 1'b1;
    tick();
    rst = 1'b0;
    flush_ack = 1'b0;
    chk_reset_vals("rstfl");
    tick();
    chk("rstfl_done2", 64'(done), 64'd0);
    chk("rstfl_busy2", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
